status_array_nway: RTL and testbench
====================================

Name: status_array_nway

Overview:
- Set-associative status array for the instruction cache: per-way, per-block valid bits plus a per-set round-robin victim pointer, held in flops.
- Replaces the single-way SRAM status store.
- Adds a self-clearing sweep after reset and on flush request, so no external initialisation is needed.
- Sits beside the tag/data arrays; read result aligns with a 1-cycle tag lookup.

Parameters:
- TAG_WIDTH, 1, width of tag propagated alongside a read.
- NUM_SETS, 16, number of sets; power of two, >=2.
- NUM_WAYS, 2, associativity; power of two, >=1.
- BLOCKS_PER_LINE, 8, valid bits per way per set.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset; asynchronous, active-low.
- i_halt  in  1  pipeline stall; freezes all state via clock_gater.
- i_flush  in  1  request to invalidate the whole array.
- i_tag  in  TAG_WIDTH  tag carried with a read.
- i_r_addr  in  ADDR_WIDTH  read set index.
- i_r_valid  in  1  read request.
- i_w_addr  in  ADDR_WIDTH  write set index.
- i_w_way  in  WAY_W  way being written.
- i_w_data  in  BLOCKS_PER_LINE  new valid bits.
- i_w_wmask  in  BLOCKS_PER_LINE  1 = update that block bit.
- i_w_alloc  in  1  write is a fill allocation; advances victim pointer.
- i_w_valid  in  1  write request.
- o_tag  out  TAG_WIDTH  registered tag of accepted read.
- o_data  out  NUM_WAYS*BLOCKS_PER_LINE  valid bits of all ways; way w occupies bits [w*BLOCKS_PER_LINE +: BLOCKS_PER_LINE].
- o_victim  out  WAY_W  victim pointer of the read set.
- o_valid  out  1  o_tag/o_data/o_victim valid.
- o_ready  out  1  accepting requests.
- o_busy  out  1  sweep in progress.

Behaviour:
- Derived widths:
  - ADDR_WIDTH = clog2(NUM_SETS).
  - WAY_W = max(1, clog2(NUM_WAYS)).
- Reset (arst_n low, async) sets:
  - o_tag=0, o_data=0, o_victim=0, o_valid=0.
  - state=SWEEP, sweep counter=0.
  - Storage is not reset directly; the sweep clears it.
- FSM states: SWEEP, READY.
  - SWEEP: each un-halted cycle clears all valid bits and the victim pointer of set[counter], then increments the counter.
  - At counter==NUM_SETS-1 the counter wraps to 0 and the FSM goes to READY.
  - The sweep takes exactly NUM_SETS un-halted cycles.
  - READY: on i_flush=1 and !i_halt, go to SWEEP with counter=0.
  - i_flush during SWEEP restarts the sweep at counter 0.
- Handshake:
  - o_ready = ~i_halt & (state==READY).
  - o_busy = (state==SWEEP).
  - Reads and writes are accepted only when o_ready=1; otherwise they are dropped silently with no state change.
  - A flush in the same cycle as an accepted write: the write is dropped; the sweep wins.
- Read:
  - Latency 1 cycle. o_valid <= accepted read.
  - o_tag <= i_tag when accepted, else 0.
  - o_data and o_victim are registered from the read set.
  - o_data = 0 and o_victim = 0 whenever o_valid = 0.
- Write:
  - For each bit b with i_w_wmask[b]=1: valid[set][way][b] <= i_w_data[b]. Other ways and bits are unchanged.
  - If i_w_alloc=1: victim[set] <= (i_w_way + 1) mod NUM_WAYS, wrapping from NUM_WAYS-1 to 0.
  - NUM_WAYS==1: victim stays 0 and i_w_way is ignored.
- Read and write to the same set in the same cycle (feature off): the read returns the pre-write contents; the write commits.
- i_halt:
  - Gated clock; no register changes, including the sweep counter and outputs.
  - o_valid holds its last value.
  - i_flush is not sampled while halted.
- Reset mid-sweep restarts the sweep from 0.

Optional Feature:
- Macro: STATUS_ARRAY_RAW_BYPASS_EN.
- Defined: for a same-cycle accepted read and write to the same set, the read result reflects the write (masked bits merged into the written way; victim updated if i_w_alloc). Read latency stays 1 cycle.
- Undefined: the read returns the old contents, as described above.

Decomposition:
- shared_params.vh holds:
  - ADDR_WIDTH and WAY_W derivation (clog2 function).
  - ROW_WIDTH = NUM_WAYS*BLOCKS_PER_LINE.
  - State encodings ST_SWEEP=1'b0, ST_READY=1'b1.
- Sub-module status_sweep_ctrl: the FSM plus sweep counter. Outputs sweep_en, sweep_addr, ready.
- Reuse the existing clock_gater for halt.

Test Plan:
- Reset release, NUM_SETS=16: o_busy=1 for exactly 16 cycles, then o_ready=1; a read of every set gives o_data=0 and o_victim=0.
- Write set 3, way 1, wmask=8'h0F, data=8'hA5, then read set 3 with i_tag=1: one cycle later o_valid=1, o_tag=1, o_data=16'h0500, o_victim=0.
- Fill allocations with i_w_alloc=1 on set 5, way 0 then way 1: o_victim reads 1 then 0, confirming the wrap.
- Same-cycle read and write to set 2: returns the old value with the macro off and the merged value with the macro on.
- Assert i_halt 3 cycles mid-sweep: o_busy is extended by exactly 3 cycles; i_r_valid during the halt gives no o_valid pulse.
- i_flush in READY after writes: 16 busy cycles follow, all sets then read 0; a flush on cycle 8 of the sweep restarts it, giving 24 busy cycles total.

Source files
------------

// File: rtl/status_array_nway_pkg.sv
// Shared types and width helpers for the n-way instruction-cache status array.
package status_array_nway_pkg;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A direct-mapped array still needs a 1-bit way/victim field.
    function automatic int way_width(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    function automatic int row_width(input int ways, input int blocks);
        return ways * blocks;
    endfunction

endpackage

// File: rtl/status_array_nway_if.sv
// Read/write request and response bundle of the status array.
interface status_array_nway_if #(
    parameter int TAG_WIDTH       = 1,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 2,
    parameter int BLOCKS_PER_LINE = 8
);
    import status_array_nway_pkg::*;

    localparam int ADDR_WIDTH = clog2(NUM_SETS);
    localparam int WAY_W      = way_width(NUM_WAYS);
    localparam int ROW_WIDTH  = row_width(NUM_WAYS, BLOCKS_PER_LINE);

    logic [TAG_WIDTH-1:0]       i_tag;
    logic [ADDR_WIDTH-1:0]      i_r_addr;
    logic                       i_r_valid;
    logic [ADDR_WIDTH-1:0]      i_w_addr;
    logic [WAY_W-1:0]           i_w_way;
    logic [BLOCKS_PER_LINE-1:0] i_w_data;
    logic [BLOCKS_PER_LINE-1:0] i_w_wmask;
    logic                       i_w_alloc;
    logic                       i_w_valid;
    logic [TAG_WIDTH-1:0]       o_tag;
    logic [ROW_WIDTH-1:0]       o_data;
    logic [WAY_W-1:0]           o_victim;
    logic                       o_valid;
    logic                       o_ready;
    logic                       o_busy;

    modport slave (
        input  i_tag, i_r_addr, i_r_valid,
        input  i_w_addr, i_w_way, i_w_data, i_w_wmask, i_w_alloc, i_w_valid,
        output o_tag, o_data, o_victim, o_valid, o_ready, o_busy
    );

    modport master (
        output i_tag, i_r_addr, i_r_valid,
        output i_w_addr, i_w_way, i_w_data, i_w_wmask, i_w_alloc, i_w_valid,
        input  o_tag, o_data, o_victim, o_valid, o_ready, o_busy
    );

endinterface

// File: rtl/status_array_nway_sweep_ctrl.sv
// Sweep sequencer: walks every set once after reset or flush to clear it.
//   state    | meaning
//   ST_SWEEP | clearing set[r_cnt] each enabled cycle, requests refused
//   ST_READY | array initialised, reads and writes accepted
module status_sweep_ctrl
    import status_array_nway_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int ADDR_WIDTH = clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_en,
    input  logic                  i_flush,
    output logic                  o_sweep_en,
    output logic [ADDR_WIDTH-1:0] o_sweep_addr,
    output logic                  o_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(NUM_SETS - 1);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
        end else if (i_en) begin
            case (r_state)
                ST_SWEEP: begin
                    if (i_flush) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_SET) begin
                        r_cnt   <= '0;
                        r_state <= ST_READY;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (i_flush) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_sweep_en   = (r_state == ST_SWEEP);
    assign o_sweep_addr = r_cnt;
    assign o_ready      = (r_state == ST_READY);

endmodule

// File: rtl/status_array_nway.sv
// Set-associative valid-bit / round-robin victim store for the I-cache.
// Optional macro STATUS_ARRAY_RAW_BYPASS_EN forwards a same-set write into the read result.
module status_array_nway
    import status_array_nway_pkg::*;
#(
    parameter int TAG_WIDTH       = 1,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 2,
    parameter int BLOCKS_PER_LINE = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                i_halt,
    input  logic                i_flush,
    status_array_nway_if.slave  bus
);

    localparam int ADDR_WIDTH = clog2(NUM_SETS);
    localparam int WAY_W      = way_width(NUM_WAYS);
    localparam int ROW_WIDTH  = row_width(NUM_WAYS, BLOCKS_PER_LINE);

    logic                  w_en;
    logic                  w_sweep_en;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;
    logic                  w_fsm_ready;
    logic                  w_ready;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [WAY_W-1:0]      w_way_eff;
    logic [WAY_W-1:0]      w_vic_next;
    logic [ROW_WIDTH-1:0]  w_row_new;
    logic [WAY_W-1:0]      w_vic_wr;
    logic [ROW_WIDTH-1:0]  w_rd_row;
    logic [WAY_W-1:0]      w_rd_vic;

    logic [ROW_WIDTH-1:0]  r_valid  [NUM_SETS];
    logic [WAY_W-1:0]      r_victim [NUM_SETS];
    logic [TAG_WIDTH-1:0]  r_o_tag;
    logic [ROW_WIDTH-1:0]  r_o_data;
    logic [WAY_W-1:0]      r_o_victim;
    logic                  r_o_valid;

    // Halt acts as a common clock enable: nothing below moves while it is high.
    assign w_en = ~i_halt;

    status_sweep_ctrl #(
        .NUM_SETS   (NUM_SETS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep_ctrl (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_en         (w_en),
        .i_flush      (i_flush),
        .o_sweep_en   (w_sweep_en),
        .o_sweep_addr (w_sweep_addr),
        .o_ready      (w_fsm_ready)
    );

    assign w_ready  = w_en & w_fsm_ready;
    assign w_rd_acc = bus.i_r_valid & w_ready;
    assign w_wr_acc = bus.i_w_valid & w_ready & ~i_flush;

    assign w_way_eff  = (NUM_WAYS == 1) ? '0 : bus.i_w_way;
    assign w_vic_next = (NUM_WAYS == 1) ? '0 : (w_way_eff + WAY_W'(1));

    always_comb begin
        w_row_new = r_valid[bus.i_w_addr];
        for (int w = 0; w < NUM_WAYS; w++) begin
            for (int b = 0; b < BLOCKS_PER_LINE; b++) begin
                if ((w_way_eff == WAY_W'(w)) && bus.i_w_wmask[b]) begin
                    w_row_new[w*BLOCKS_PER_LINE + b] = bus.i_w_data[b];
                end
            end
        end
    end

    assign w_vic_wr = bus.i_w_alloc ? w_vic_next : r_victim[bus.i_w_addr];

    always_ff @(posedge clk) begin
        if (w_en) begin
            if (w_sweep_en) begin
                r_valid[w_sweep_addr]  <= '0;
                r_victim[w_sweep_addr] <= '0;
            end else if (w_wr_acc) begin
                r_valid[bus.i_w_addr]  <= w_row_new;
                r_victim[bus.i_w_addr] <= w_vic_wr;
            end
        end
    end

    always_comb begin
        w_rd_row = r_valid[bus.i_r_addr];
        w_rd_vic = r_victim[bus.i_r_addr];
`ifdef STATUS_ARRAY_RAW_BYPASS_EN
        if (w_wr_acc && (bus.i_r_addr == bus.i_w_addr)) begin
            w_rd_row = w_row_new;
            w_rd_vic = w_vic_wr;
        end
`endif
    end

    // Response fields are zeroed whenever no read was accepted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_o_valid  <= 1'b0;
            r_o_tag    <= '0;
            r_o_data   <= '0;
            r_o_victim <= '0;
        end else if (w_en) begin
            r_o_valid  <= w_rd_acc;
            r_o_tag    <= w_rd_acc ? bus.i_tag : '0;
            r_o_data   <= w_rd_acc ? w_rd_row  : '0;
            r_o_victim <= w_rd_acc ? w_rd_vic  : '0;
        end
    end

    assign bus.o_valid  = r_o_valid;
    assign bus.o_tag    = r_o_tag;
    assign bus.o_data   = r_o_data;
    assign bus.o_victim = r_o_victim;
    assign bus.o_ready  = w_ready;
    assign bus.o_busy   = w_sweep_en;

endmodule

// File: tb/tb_status_array_nway.sv
// Scoreboard bench for status_array_nway with directed vectors.
module tb_status_array_nway;

    localparam int TAG_WIDTH       = 1;
    localparam int NUM_SETS        = 16;
    localparam int NUM_WAYS        = 2;
    localparam int BLOCKS_PER_LINE = 8;

    logic clk     = 1'b0;
    logic arst_n  = 1'b0;
    logic i_halt  = 1'b0;
    logic i_flush = 1'b0;

    status_array_nway_if #(
        .TAG_WIDTH(TAG_WIDTH), .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS), .BLOCKS_PER_LINE(BLOCKS_PER_LINE)
    ) bus ();

    status_array_nway #(
        .TAG_WIDTH(TAG_WIDTH), .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS), .BLOCKS_PER_LINE(BLOCKS_PER_LINE)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_halt  (i_halt),
        .i_flush (i_flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]  tag;
        logic [15:0] data;
        logic [0:0]  victim;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic edge_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Remember whether the last rising edge actually clocked the design.
    always @(posedge clk) edge_en = ~i_halt;

    always @(negedge clk) begin
        if (arst_n && edge_en && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected o_valid", 32'(bus.o_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("o_tag",    32'(bus.o_tag),    32'(mon_e.tag));
                check("o_data",   32'(bus.o_data),   32'(mon_e.data));
                check("o_victim", 32'(bus.o_victim), 32'(mon_e.victim));
            end
        end
    end

    task automatic do_read(input int set, input logic tag, input logic [15:0] data, input logic vic);
        bus.i_r_valid = 1'b1;
        bus.i_r_addr  = 4'(set);
        bus.i_tag     = tag;
        exp_q.push_back('{tag: tag, data: data, victim: vic});
        @(negedge clk);
        bus.i_r_valid = 1'b0;
    endtask

    task automatic drive_write(input int set, input int way, input logic [7:0] mask,
                               input logic [7:0] data, input logic alloc);
        bus.i_w_valid = 1'b1;
        bus.i_w_addr  = 4'(set);
        bus.i_w_way   = 1'(way);
        bus.i_w_wmask = mask;
        bus.i_w_data  = data;
        bus.i_w_alloc = alloc;
    endtask

    task automatic do_write(input int set, input int way, input logic [7:0] mask,
                            input logic [7:0] data, input logic alloc);
        drive_write(set, way, mask, data, alloc);
        @(negedge clk);
        bus.i_w_valid = 1'b0;
    endtask

    // Counts busy samples from the current negedge; optionally re-flushes or halts mid-sweep.
    task automatic count_busy(input int flush_at, input int halt_at, output int cnt);
        cnt = 0;
        while (bus.o_busy && cnt < 100) begin
            cnt++;
            i_flush       = (cnt == flush_at);
            i_halt        = (halt_at != 0) && (cnt >= halt_at) && (cnt < halt_at + 3);
            bus.i_r_valid = i_halt;
            bus.i_r_addr  = '0;
            if (halt_at != 0 && cnt > halt_at && cnt <= halt_at + 3)
                check("no o_valid across halt", 32'(bus.o_valid), 32'd0);
            @(negedge clk);
        end
        i_flush       = 1'b0;
        i_halt        = 1'b0;
        bus.i_r_valid = 1'b0;
    endtask

    task automatic flush_and_count(input int flush_at, input int halt_at, output int cnt);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        count_busy(flush_at, halt_at, cnt);
    endtask

    initial begin
        int cnt;
        bus.i_tag     = '0;
        bus.i_r_addr  = '0;
        bus.i_r_valid = 1'b0;
        bus.i_w_addr  = '0;
        bus.i_w_way   = '0;
        bus.i_w_data  = '0;
        bus.i_w_wmask = '0;
        bus.i_w_alloc = 1'b0;
        bus.i_w_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset o_valid",  32'(bus.o_valid),  32'd0);
        check("reset o_tag",    32'(bus.o_tag),    32'd0);
        check("reset o_data",   32'(bus.o_data),   32'd0);
        check("reset o_victim", 32'(bus.o_victim), 32'd0);
        check("reset o_busy",   32'(bus.o_busy),   32'd1);
        check("reset o_ready",  32'(bus.o_ready),  32'd0);

        arst_n = 1'b1;
        count_busy(0, 0, cnt);
        check("initial sweep length", 32'(cnt), 32'd16);
        check("ready after sweep", 32'(bus.o_ready), 32'd1);

        for (int s = 0; s < NUM_SETS; s++) do_read(s, 1'(s & 1), 16'h0000, 1'b0);

        do_write(3, 1, 8'h0F, 8'hA5, 1'b0);
        do_read(3, 1'b1, 16'h0500, 1'b0);

        do_write(5, 0, 8'hFF, 8'h3C, 1'b1);
        do_read(5, 1'b0, 16'h003C, 1'b1);
        do_write(5, 1, 8'h0F, 8'hFF, 1'b1);
        do_read(5, 1'b1, 16'h0F3C, 1'b0);

        do_write(2, 0, 8'hFF, 8'h11, 1'b0);
        drive_write(2, 0, 8'hF0, 8'h77, 1'b1);
`ifdef STATUS_ARRAY_RAW_BYPASS_EN
        do_read(2, 1'b1, 16'h0071, 1'b1);
`else
        do_read(2, 1'b1, 16'h0011, 1'b0);
`endif
        bus.i_w_valid = 1'b0;
        do_read(2, 1'b0, 16'h0071, 1'b1);

        // Halt in READY: o_valid holds, a write under halt is lost.
        do_read(6, 1'b1, 16'h0000, 1'b0);
        i_halt = 1'b1;
        drive_write(4, 0, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        check("o_valid held under halt", 32'(bus.o_valid), 32'd1);
        check("o_ready low under halt", 32'(bus.o_ready), 32'd0);
        i_halt = 1'b0;
        bus.i_w_valid = 1'b0;
        do_read(4, 1'b0, 16'h0000, 1'b0);

        // Write coincident with flush is dropped; the sweep wins.
        drive_write(7, 1, 8'hFF, 8'hFF, 1'b1);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        bus.i_w_valid = 1'b0;
        count_busy(0, 0, cnt);
        check("flush sweep length", 32'(cnt), 32'd16);
        do_read(2, 1'b0, 16'h0000, 1'b0);
        do_read(3, 1'b1, 16'h0000, 1'b0);
        do_read(5, 1'b0, 16'h0000, 1'b0);
        do_read(7, 1'b1, 16'h0000, 1'b0);

        flush_and_count(8, 0, cnt);
        check("restarted sweep length", 32'(cnt), 32'd24);

        flush_and_count(0, 5, cnt);
        check("halted sweep length", 32'(cnt), 32'd19);
        do_read(9, 1'b1, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
